pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_ctrl_if.sv | 42 ++++
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared types and constants for the pipeline hazard controller.
// Rev    : 1.0  initial release
// ============================================================================
package pipe_pkg;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    MUL = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXALU  = 2'b01;
  localparam logic [1:0] FWD_MEMALU = 2'b10;
  localparam logic [1:0] FWD_MEMLD  = 2'b11;

  localparam int MUL_LAT_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl_if
// Brief  : Pipeline-side signals seen by the hazard controller.
// Rev    : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if;

  logic [4:0]  drs;
  logic [4:0]  drt;
  logic        duse_rs;
  logic        duse_rt;
  logic        dmul;
  logic        dkill;
  logic [4:0]  ern;
  logic        ewreg;
  logic        em2reg;
  logic [4:0]  mrn;
  logic        mwreg;
  logic        mm2reg;
  logic        wpcir;
  logic        dbubble;
  logic        estall;
  logic [1:0]  fwda;
  logic [1:0]  fwdb;
  logic        mbusy;
  logic [15:0] stall_count;

  modport master (
    output drs, drt, duse_rs, duse_rt, dmul, dkill,
    output ern, ewreg, em2reg, mrn, mwreg, mm2reg,
    input  wpcir, dbubble, estall, fwda, fwdb, mbusy, stall_count
  );

  modport slave (
    input  drs, drt, duse_rs, duse_rt, dmul, dkill,
    input  ern, ewreg, em2reg, mrn, mwreg, mm2reg,
    output wpcir, dbubble, estall, fwda, fwdb, mbusy, stall_count
  );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module : pipe_fwd_sel
// Brief  : Operand forwarding select for one source register.
// Rev    : 1.0  initial release
// ============================================================================
module pipe_fwd_sel
  import pipe_pkg::*;
(
  input  wire logic [4:0] i_src,
  input  wire logic [4:0] i_ern,
  input  wire logic       i_ewreg,
  input  wire logic       i_em2reg,
  input  wire logic [4:0] i_mrn,
  input  wire logic       i_mwreg,
  input  wire logic       i_mm2reg,
  output logic      [1:0] o_fwd
);

  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit  = i_ewreg & (i_ern != 5'd0) & (i_ern == i_src);
  assign w_mem_hit = i_mwreg & (i_mrn != 5'd0) & (i_mrn == i_src);

  // An EX load hit is not forwardable; the load-use stall covers it.
  always_comb begin
    o_fwd = FWD_RF;
    if (w_ex_hit && !i_em2reg) begin
      o_fwd = FWD_EXALU;
    end else if (w_mem_hit && i_mm2reg) begin
      o_fwd = FWD_MEMLD;
    end else if (w_mem_hit) begin
      o_fwd = FWD_MEMALU;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl
// Brief  : Load-use / multicycle stall control, forwarding and stall stats.
// Rev    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  wire logic         clock,
  input  wire logic         resetn,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [3:0] c_cnt_init = 4'(MUL_LAT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [15:0] r_stall_count;

  logic w_luh;
  logic w_wpcir;
  logic w_dbubble;
  logic w_estall;
  logic w_mbusy;

  assign w_luh = bus.ewreg & bus.em2reg & (bus.ern != 5'd0) &
                 ((bus.duse_rs & (bus.ern == bus.drs)) |
                  (bus.duse_rt & (bus.ern == bus.drt)));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs are forced to the idle pattern while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wpcir     = 1'b1;
    w_dbubble   = 1'b0;
    w_estall    = 1'b0;
    w_mbusy     = 1'b0;
    if (resetn) begin
      if (bus.dkill) begin
        w_dbubble   = 1'b1;
        w_state_nxt = RUN;
        w_cnt_nxt   = 4'd0;
      end else if (r_state == MUL) begin
        w_wpcir  = 1'b0;
        w_estall = 1'b1;
        w_mbusy  = 1'b1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end else if (w_luh) begin
        w_wpcir   = 1'b0;
        w_dbubble = 1'b1;
      end else if (bus.dmul) begin
        w_state_nxt = MUL;
        w_cnt_nxt   = c_cnt_init;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_stall_count <= 16'd0;
    end else if (!w_wpcir && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign bus.wpcir       = w_wpcir;
  assign bus.dbubble     = w_dbubble;
  assign bus.estall      = w_estall;
  assign bus.mbusy       = w_mbusy;
  assign bus.stall_count = r_stall_count;

  pipe_fwd_sel u_fwd_rs (
    .i_src    (bus.drs),
    .i_ern    (bus.ern),
    .i_ewreg  (bus.ewreg),
    .i_em2reg (bus.em2reg),
    .i_mrn    (bus.mrn),
    .i_mwreg  (bus.mwreg),
    .i_mm2reg (bus.mm2reg),
    .o_fwd    (bus.fwda)
  );

  pipe_fwd_sel u_fwd_rt (
    .i_src    (bus.drt),
    .i_ern    (bus.ern),
    .i_ewreg  (bus.ewreg),
    .i_em2reg (bus.em2reg),
    .i_mrn    (bus.mrn),
    .i_mwreg  (bus.mwreg),
    .i_mm2reg (bus.mm2reg),
    .o_fwd    (bus.fwdb)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_hazard_ctrl
// Brief  : Scoreboard testbench for pipe_hazard_ctrl (MUL_LAT = 4).
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int c_lat = 4;

  typedef struct {
    logic        wpcir;
    logic        dbubble;
    logic        estall;
    logic        mbusy;
    logic        chk_mbusy;
    logic [1:0]  fwda;
    logic [1:0]  fwdb;
    logic [15:0] sc;
  } exp_t;

  logic clock;
  logic resetn;
  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MUL_LAT(c_lat)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_mul_left = 0;
  int   m_stalls = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] r, input logic [4:0] en,
                                          input logic ew, input logic em,
                                          input logic [4:0] mn, input logic mw,
                                          input logic mm);
    if (ew && !em && en != 0 && en == r) return 2'b01;
    if (mw && mm && mn != 0 && mn == r) return 2'b11;
    if (mw && !mm && mn != 0 && mn == r) return 2'b10;
    return 2'b00;
  endfunction

  // Apply one ID/EX/MEM snapshot after an edge and queue what must be seen.
  task automatic cycle(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic mul,
                       input logic kill, input logic [4:0] en, input logic ew,
                       input logic em, input logic [4:0] mn, input logic mw,
                       input logic mm);
    exp_t e;
    logic luh;
    @(posedge clock);
    #1;
    bus.drs = rs;  bus.drt = rt;  bus.duse_rs = urs; bus.duse_rt = urt;
    bus.dmul = mul; bus.dkill = kill;
    bus.ern = en;  bus.ewreg = ew; bus.em2reg = em;
    bus.mrn = mn;  bus.mwreg = mw; bus.mm2reg = mm;
    luh = ew && em && en != 0 && ((urs && en == rs) || (urt && en == rt));
    e.wpcir = 1'b1; e.dbubble = 1'b0; e.estall = 1'b0;
    e.mbusy = (m_mul_left > 0); e.chk_mbusy = 1'b1;
    e.sc = 16'(m_stalls);
    e.fwda = fwd_ref(rs, en, ew, em, mn, mw, mm);
    e.fwdb = fwd_ref(rt, en, ew, em, mn, mw, mm);
    if (kill) begin
      e.dbubble = 1'b1; e.chk_mbusy = 1'b0;
      m_mul_left = 0;
    end else if (m_mul_left > 0) begin
      e.wpcir = 1'b0; e.estall = 1'b1;
      m_mul_left--;
    end else if (luh) begin
      e.wpcir = 1'b0; e.dbubble = 1'b1;
    end else if (mul) begin
      m_mul_left = c_lat - 1;
    end
    if (!e.wpcir && m_stalls < 65535) m_stalls++;
    sb.push_back(e);
  endtask

  task automatic idle();
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("wpcir", 16'(bus.wpcir), 16'(e.wpcir));
      chk("dbubble", 16'(bus.dbubble), 16'(e.dbubble));
      chk("estall", 16'(bus.estall), 16'(e.estall));
      if (e.chk_mbusy) chk("mbusy", 16'(bus.mbusy), 16'(e.mbusy));
      chk("fwda", 16'(bus.fwda), 16'(e.fwda));
      chk("fwdb", 16'(bus.fwdb), 16'(e.fwdb));
      chk("stall_count", bus.stall_count, e.sc);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    bus.drs = 0; bus.drt = 0; bus.duse_rs = 0; bus.duse_rt = 0;
    bus.dmul = 0; bus.dkill = 0; bus.ern = 0; bus.ewreg = 0; bus.em2reg = 0;
    bus.mrn = 0; bus.mwreg = 0; bus.mm2reg = 0;
    #12;
    chk("rst_wpcir", 16'(bus.wpcir), 16'd1);
    chk("rst_dbubble", 16'(bus.dbubble), 16'd0);
    chk("rst_estall", 16'(bus.estall), 16'd0);
    chk("rst_mbusy", 16'(bus.mbusy), 16'd0);
    chk("rst_stall_count", bus.stall_count, 16'd0);
    #10 resetn = 1'b1;

    // Load-use on r5, then the load sits in MEM and is forwarded.
    cycle(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    cycle(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    // EX beats MEM on rt; r0 never forwards.
    cycle(5'd1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    cycle(5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
    // Full multicycle operation.
    cycle(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (5) idle();
    // Kill on the second MUL cycle.
    cycle(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle();
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle();
    // Kill together with a load-use hazard.
    cycle(5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    idle();

    for (int i = 0; i < 1500; i++) begin
      cycle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 9) == 0),
            5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
    end
    idle();

    // Continuous load-use stall drives the counter into saturation.
    for (int i = 0; i < 65540; i++) begin
      cycle(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    end
    @(negedge clock);
    #1;
    chk("sat_stall_count", bus.stall_count, 16'hFFFF);

    // Asynchronous reset while a multicycle op is in flight.
    cycle(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle();
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_mbusy", 16'(bus.mbusy), 16'd0);
    chk("mid_rst_stall_count", bus.stall_count, 16'd0);
    chk("mid_rst_wpcir", 16'(bus.wpcir), 16'd1);
    m_mul_left = 0;
    m_stalls = 0;
    @(posedge clock);
    #3 resetn = 1'b1;
    repeat (3) idle();

    @(negedge clock);
    #1;
    chk("sb_drain", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
